// File: rtl/alu_rr_sched_pkg.sv
// Shared definitions for the round-robin ALU scheduler.
// Holds the ALU opcode values, the scheduler FSM state encoding and the
// 7-segment patterns for hex digits 0..F (bit order {dp,g,f,e,d,c,b,a}).
package alu_rr_sched_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_OR  = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [7:0] SEG_0 = 8'h3F;
  localparam logic [7:0] SEG_1 = 8'h06;
  localparam logic [7:0] SEG_2 = 8'h5B;
  localparam logic [7:0] SEG_3 = 8'h4F;
  localparam logic [7:0] SEG_4 = 8'h66;
  localparam logic [7:0] SEG_5 = 8'h6D;
  localparam logic [7:0] SEG_6 = 8'h7D;
  localparam logic [7:0] SEG_7 = 8'h07;
  localparam logic [7:0] SEG_8 = 8'h7F;
  localparam logic [7:0] SEG_9 = 8'h6F;
  localparam logic [7:0] SEG_A = 8'h77;
  localparam logic [7:0] SEG_B = 8'h7C;
  localparam logic [7:0] SEG_C = 8'h39;
  localparam logic [7:0] SEG_D = 8'h5E;
  localparam logic [7:0] SEG_E = 8'h79;
  localparam logic [7:0] SEG_F = 8'h71;

endpackage

// File: rtl/alu_rr_sched_alu.sv
// Parametric combinational ALU.
// Ports: a, b (W-bit operands), op (2-bit opcode), y (W-bit result).
// All results wrap modulo 2^W; there is no carry or borrow output.
module alu_rr_sched_alu
  import alu_rr_sched_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [1:0]   op,
  output logic [W-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_rr_sched.sv
// Round-robin scheduler sharing one ALU between two requesters.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   reqN_valid/a/b/op        command from requester N (N = 0, 1)
//   reqN_ready               command accepted this cycle (combinational)
//   respN_valid              one-cycle strobe: result belongs to requester N
//   result                   last registered ALU result
//   busy                     scheduler is not idle
//   disp_en                  display enable
//   seg_out                  registered 7-segment pattern of result[3:0]
// One operation takes three cycles: accept (IDLE), EXEC, RESP.
module alu_rr_sched
  import alu_rr_sched_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic [1:0]   req0_op,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic [1:0]   req1_op,
  output logic         req1_ready,
  output logic         resp0_valid,
  output logic         resp1_valid,
  output logic [W-1:0] result,
  output logic         busy,
  input  logic         disp_en,
  output logic [7:0]   seg_out
);

  state_t       state_q, state_d;
  logic         last_grant_q;
  logic         grant;
  logic         accept;
  logic [W-1:0] a_p1, b_p1;
  logic [1:0]   op_p1;
  logic         id_p1;
  logic [W-1:0] alu_y;
  logic [W-1:0] result_p2;
  logic         shown_q;
  logic [7:0]   seg_q;

  function automatic logic [7:0] seg_decode(input logic [3:0] nib);
    logic [7:0] pat;
    pat = 8'h00;
    case (nib)
      4'h0: pat = SEG_0;
      4'h1: pat = SEG_1;
      4'h2: pat = SEG_2;
      4'h3: pat = SEG_3;
      4'h4: pat = SEG_4;
      4'h5: pat = SEG_5;
      4'h6: pat = SEG_6;
      4'h7: pat = SEG_7;
      4'h8: pat = SEG_8;
      4'h9: pat = SEG_9;
      4'hA: pat = SEG_A;
      4'hB: pat = SEG_B;
      4'hC: pat = SEG_C;
      4'hD: pat = SEG_D;
      4'hE: pat = SEG_E;
      4'hF: pat = SEG_F;
      default: pat = 8'h00;
    endcase
    return pat;
  endfunction

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ~last_grant_q;
    else if (req1_valid)          grant = 1'b1;
  end

  assign req0_ready = (state_q == ST_IDLE) && req0_valid && !grant;
  assign req1_ready = (state_q == ST_IDLE) && req1_valid &&  grant;
  assign accept     = req0_ready || req1_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Stage p1: operands captured from the winning requester in the accept cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      a_p1         <= '0;
      b_p1         <= '0;
      op_p1        <= OP_ADD;
      id_p1        <= 1'b0;
    end else if (accept) begin
      last_grant_q <= grant;
      a_p1         <= grant ? req1_a  : req0_a;
      b_p1         <= grant ? req1_b  : req0_b;
      op_p1        <= grant ? req1_op : req0_op;
      id_p1        <= grant;
    end
  end

  alu_rr_sched_alu #(.W(W)) u_alu (
    .a  (a_p1),
    .b  (b_p1),
    .op (op_p1),
    .y  (alu_y)
  );

  // Stage p2: ALU result registered at the end of EXEC, held until the next op
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_p2 <= '0;
      shown_q   <= 1'b0;
    end else begin
      if (state_q == ST_EXEC) result_p2 <= alu_y;
      if (state_q == ST_RESP) shown_q   <= 1'b1;
    end
  end

  // Display stage: the RESP term lets the new pattern land in the cycle after RESP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) seg_q <= 8'h00;
    else if (disp_en && (shown_q || state_q == ST_RESP))
      seg_q <= seg_decode(result_p2[3:0]);
    else
      seg_q <= 8'h00;
  end

  assign resp0_valid = (state_q == ST_RESP) && !id_p1;
  assign resp1_valid = (state_q == ST_RESP) &&  id_p1;
  assign busy        = (state_q != ST_IDLE);
  assign result      = result_p2;
  assign seg_out     = seg_q;

endmodule

// File: tb/tb_alu_rr_sched.sv
module tb_alu_rr_sched;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req1_valid;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0]   req0_op, req1_op;
  logic         req0_ready, req1_ready;
  logic         resp0_valid, resp1_valid;
  logic [W-1:0] result;
  logic         busy;
  logic         disp_en;
  logic [7:0]   seg_out;

  alu_rr_sched #(.W(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op), .req1_ready(req1_ready),
    .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
    .result(result), .busy(busy), .disp_en(disp_en), .seg_out(seg_out)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  logic lg;  // model of which requester won last

  logic [7:0] seg_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                               8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  typedef struct {
    logic       v0;
    logic [3:0] a0, b0;
    logic [1:0] op0;
    logic       v1;
    logic [3:0] a1, b1;
    logic [1:0] op1;
    logic       id;
    logic [3:0] res;
    logic [7:0] seg;
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] model_alu(input int a, input int b, input int op);
    int s;
    case (op)
      0:       s = (a + b) % 16;
      1:       s = (a - b + 16) % 16;
      2:       s = a | b;
      default: s = a ^ b;
    endcase
    return s[3:0];
  endfunction

  // Starts at posedge+1 of an idle cycle, ends at posedge+1 of the cycle after RESP.
  task automatic run_txn(input string nm,
                         input logic v0, input logic [3:0] a0, input logic [3:0] b0, input logic [1:0] op0,
                         input logic v1, input logic [3:0] a1, input logic [3:0] b1, input logic [1:0] op1,
                         input logic exp_id, input logic [3:0] exp_res, input logic [7:0] exp_seg);
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
    #1;
    chk({nm, "_rdy0"}, 32'(req0_ready), 32'(!exp_id));
    chk({nm, "_rdy1"}, 32'(req1_ready), 32'(exp_id));
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk({nm, "_busy_exec"}, 32'(busy), 32'd1);
    chk({nm, "_resp_exec"}, 32'({resp1_valid, resp0_valid}), 32'd0);
    step();
    chk({nm, "_busy_resp"}, 32'(busy), 32'd1);
    chk({nm, "_resp"}, 32'({resp1_valid, resp0_valid}), exp_id ? 32'd2 : 32'd1);
    chk({nm, "_result"}, 32'(result), 32'(exp_res));
    step();
    chk({nm, "_busy_idle"}, 32'(busy), 32'd0);
    chk({nm, "_resp_after"}, 32'({resp1_valid, resp0_valid}), 32'd0);
    chk({nm, "_seg"}, 32'(seg_out), 32'(exp_seg));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    time t_resp [4];
    rst = 1'b1; disp_en = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_result", 32'(result), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_resp", 32'({resp1_valid, resp0_valid}), 32'd0);
    chk("reset_ready", 32'({req1_ready, req0_ready}), 32'd0);
    chk("reset_seg", 32'(seg_out), 32'd0);
    rst = 1'b0;
    lg = 1'b1;

    // Tie from reset: both held continuously, grants alternate 0,1,0,1.
    req0_valid = 1'b1; req0_a = 4'h1; req0_b = 4'h1; req0_op = 2'b00;
    req1_valid = 1'b1; req1_a = 4'hF; req1_b = 4'h5; req1_op = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("tie%0d_rdy", k), 32'({req1_ready, req0_ready}), (k % 2) ? 32'd2 : 32'd1);
      step();
      chk($sformatf("tie%0d_exec_rdy", k), 32'({req1_ready, req0_ready}), 32'd0);
      chk($sformatf("tie%0d_exec_resp", k), 32'({resp1_valid, resp0_valid}), 32'd0);
      step();
      t_resp[k] = $time;
      chk($sformatf("tie%0d_resp", k), 32'({resp1_valid, resp0_valid}), (k % 2) ? 32'd2 : 32'd1);
      chk($sformatf("tie%0d_result", k), 32'(result), (k % 2) ? 32'hA : 32'h2);
      chk($sformatf("tie%0d_resp_rdy", k), 32'({req1_ready, req0_ready}), 32'd0);
      step();
      chk($sformatf("tie%0d_seg", k), 32'(seg_out), (k % 2) ? 32'h77 : 32'h5B);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int k = 1; k < 4; k++)
      chk($sformatf("tie_spacing%0d", k), 32'(t_resp[k] - t_resp[k-1]), 32'd30);
    lg = 1'b1;

    // Table-driven vectors (last winner is requester 1 at this point).
    vt[0] = '{1'b1, 4'h3, 4'h4, 2'b00, 1'b0, 4'h0, 4'h0, 2'b00, 1'b0, 4'h7, 8'h07};
    vt[1] = '{1'b0, 4'h0, 4'h0, 2'b00, 1'b1, 4'h2, 4'h5, 2'b01, 1'b1, 4'hD, 8'h5E};
    vt[2] = '{1'b1, 4'hC, 4'h3, 2'b10, 1'b1, 4'hF, 4'h5, 2'b11, 1'b0, 4'hF, 8'h71};
    vt[3] = '{1'b1, 4'hC, 4'h3, 2'b10, 1'b1, 4'hF, 4'h5, 2'b11, 1'b1, 4'hA, 8'h77};
    vt[4] = '{1'b1, 4'hF, 4'h1, 2'b00, 1'b0, 4'h0, 4'h0, 2'b00, 1'b0, 4'h0, 8'h3F};
    vt[5] = '{1'b0, 4'h0, 4'h0, 2'b00, 1'b1, 4'h0, 4'h1, 2'b01, 1'b1, 4'hF, 8'h71};
    vt[6] = '{1'b1, 4'h8, 4'h1, 2'b10, 1'b0, 4'h0, 4'h0, 2'b00, 1'b0, 4'h9, 8'h6F};
    vt[7] = '{1'b1, 4'h2, 4'h2, 2'b00, 1'b1, 4'h6, 4'h3, 2'b11, 1'b1, 4'h5, 8'h6D};
    for (int i = 0; i < 8; i++)
      run_txn($sformatf("vec%0d", i), vt[i].v0, vt[i].a0, vt[i].b0, vt[i].op0,
              vt[i].v1, vt[i].a1, vt[i].b1, vt[i].op1, vt[i].id, vt[i].res, vt[i].seg);

    // Display disabled while an op completes, then enabled.
    disp_en = 1'b0;
    run_txn("dispoff", 1'b1, 4'hC, 4'h3, 2'b10, 1'b0, 4'h0, 4'h0, 2'b00, 1'b0, 4'hF, 8'h00);
    disp_en = 1'b1;
    #1;
    chk("dispon_same_cycle", 32'(seg_out), 32'h00);
    step();
    chk("dispon_seg", 32'(seg_out), 32'h71);

    // Reset pulsed during EXEC of a req1 operation.
    req1_valid = 1'b1; req1_a = 4'h2; req1_b = 4'h5; req1_op = 2'b01;
    #1;
    chk("rstexec_rdy1", 32'(req1_ready), 32'd1);
    step();
    req1_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rstexec_result", 32'(result), 32'd0);
    chk("rstexec_seg", 32'(seg_out), 32'd0);
    chk("rstexec_busy", 32'(busy), 32'd0);
    chk("rstexec_resp", 32'(resp1_valid), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("rstexec_noresp%0d", k), 32'({resp1_valid, resp0_valid}), 32'd0);
      chk($sformatf("rstexec_idle%0d", k), 32'(busy), 32'd0);
    end
    run_txn("rst_tie", 1'b1, 4'h1, 4'h1, 2'b00, 1'b1, 4'hF, 4'h5, 2'b11, 1'b0, 4'h2, 8'h5B);
    lg = 1'b0;

    // req0 raised while busy and dropped before it could be accepted.
    req1_valid = 1'b1; req1_a = 4'h3; req1_b = 4'h3; req1_op = 2'b11;
    #1;
    chk("drop_rdy1", 32'(req1_ready), 32'd1);
    step();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_a = 4'h1; req0_b = 4'h1; req0_op = 2'b00;
    #1;
    chk("drop_rdy0_exec", 32'(req0_ready), 32'd0);
    step();
    chk("drop_rdy0_resp", 32'(req0_ready), 32'd0);
    chk("drop_resp1", 32'({resp1_valid, resp0_valid}), 32'd2);
    req0_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("drop_noresp%0d", k), 32'({resp0_valid, busy, req0_ready}), 32'd0);
    end
    lg = 1'b1;

    // req0 raised while busy and held: arbitrated on the next idle cycle.
    req1_valid = 1'b1; req1_a = 4'h7; req1_b = 4'h1; req1_op = 2'b00;
    #1;
    chk("wait_rdy1", 32'(req1_ready), 32'd1);
    step();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_a = 4'h5; req0_b = 4'h2; req0_op = 2'b01;
    #1;
    chk("wait_rdy0_exec", 32'(req0_ready), 32'd0);
    step();
    chk("wait_rdy0_resp", 32'(req0_ready), 32'd0);
    chk("wait_result1", 32'(result), 32'h8);
    step();
    run_txn("wait", 1'b1, 4'h5, 4'h2, 2'b01, 1'b0, 4'h0, 4'h0, 2'b00, 1'b0, 4'h3, 8'h4F);
    lg = 1'b0;

    // Randomized transactions against the transaction-level model.
    rst = 1'b1;
    step();
    rst = 1'b0;
    lg = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic       v0, v1, win, de;
      logic [3:0] a0, b0, a1, b1, r;
      logic [1:0] op0, op1;
      int         sel;
      sel = int'($urandom_range(0, 3));
      v0 = sel[0]; v1 = sel[1];
      if (!v0 && !v1) begin
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        chk($sformatf("rnd%0d_idle_rdy", i), 32'({req1_ready, req0_ready}), 32'd0);
        step();
        chk($sformatf("rnd%0d_idle_busy", i), 32'(busy), 32'd0);
        continue;
      end
      a0 = 4'($urandom); b0 = 4'($urandom); op0 = 2'($urandom);
      a1 = 4'($urandom); b1 = 4'($urandom); op1 = 2'($urandom);
      de = 1'($urandom);
      disp_en = de;
      win = (v0 && v1) ? ~lg : v1;
      r = win ? model_alu(int'(a1), int'(b1), int'(op1)) : model_alu(int'(a0), int'(b0), int'(op0));
      run_txn($sformatf("rnd%0d", i), v0, a0, b0, op0, v1, a1, b1, op1,
              win, r, de ? seg_tab[r] : 8'h00);
      lg = win;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
